// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus driver and its sequencer.
`timescale 1ns/1ps
package lcd_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_HOLD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        ACK
    } lcd_state_e;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DDRAM_SET     = 8'h80;

    localparam int INIT_LEN = 6;

    // Power-up command list: function set three times, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = FUNC_SET_8B2L;
            3'd3:             cmd = DISP_ON;
            3'd4:             cmd = CLEAR;
            default:          cmd = ENTRY_INC;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter: load N-1 on entry to a timed state and it reports
// done on the Nth cycle. It stops at zero and never wraps. The armed flag
// distinguishes "never loaded since reset" from "count expired".
`timescale 1ns/1ps
module lcd_delay_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done,
    output logic             armed
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             armed_d, armed_q;

    // Next count: reload on request, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            cnt_d   = load_val;
            armed_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign done  = armed_q && (cnt_q == '0);
    assign armed = armed_q;

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit bus driver: runs the power-up init list, then issues one
// byte per sequencer request as a setup / E-pulse / execution-wait cycle and
// acknowledges it with a single-cycle Cuenta pulse. All outputs are flops
// loaded from the next-state decode, so they align exactly with the states.
`timescale 1ns/1ps
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int CNT_W   = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] DatoLCD,
    input  logic       Lista,
    input  logic       Linea2,
    output logic       Cuenta,
    output logic       Listo,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);

    // Counter load values are duration minus one. The first power-up cycle is
    // spent arming the counter, so that wait loads one less.
    localparam logic [CNT_W-1:0] LD_PWRUP = (T_PWRUP > 1) ? CNT_W'(T_PWRUP - 2) : '0;
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);
    localparam logic [2:0]       IDX_LAST = 3'(INIT_LEN - 1);

    // Clear Display needs the long execution wait; everything else the short one.
    function automatic logic [CNT_W-1:0] hold_load(input logic [7:0] db, input logic rs);
        return (!rs && db == CLEAR) ? LD_CLR : LD_CMD;
    endfunction

    lcd_state_e       state_d, state_q;
    logic [2:0]       idx_d, idx_q;
    logic [7:0]       db_d, db_q;
    logic             rs_d, rs_q;
    logic             e_d, e_q;
    logic             cuenta_d, cuenta_q;
    logic             listo_d, listo_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_done;
    logic             cnt_armed;

    lcd_delay_cnt #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk      (Clk),
        .rst      (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .done     (cnt_done),
        .armed    (cnt_armed)
    );

    // Next-state, latched bus byte and delay-counter control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        db_d         = db_q;
        rs_d         = rs_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_done || (!cnt_armed && T_PWRUP == 1)) begin
                    state_d      = INIT_SETUP;
                    idx_d        = 3'd0;
                    db_d         = init_rom(3'd0);
                    rs_d         = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                end else if (!cnt_armed) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_PWRUP;
                end
            end
            INIT_SETUP, SETUP: begin
                if (cnt_done) begin
                    state_d      = (state_q == INIT_SETUP) ? INIT_PULSE : PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_PULSE;
                end
            end
            INIT_PULSE, PULSE: begin
                if (cnt_done) begin
                    state_d      = (state_q == INIT_PULSE) ? INIT_HOLD : HOLD;
                    cnt_load     = 1'b1;
                    cnt_load_val = hold_load(db_q, rs_q);
                end
            end
            INIT_HOLD: begin
                if (cnt_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = INIT_SETUP;
                        idx_d        = idx_q + 3'd1;
                        db_d         = init_rom(idx_q + 3'd1);
                        cnt_load     = 1'b1;
                        cnt_load_val = LD_SETUP;
                    end
                end
            end
            IDLE: begin
                if (Linea2) begin
                    state_d      = SETUP;
                    db_d         = DDRAM_SET | DatoLCD;
                    rs_d         = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                end else if (Lista) begin
                    state_d      = SETUP;
                    db_d         = DatoLCD;
                    rs_d         = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_SETUP;
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

    // Output decode from the next state so each registered output tracks its state exactly.
    always_comb begin
        e_d      = (state_d == INIT_PULSE) || (state_d == PULSE);
        cuenta_d = (state_d == ACK);
        listo_d  = (state_d == IDLE);
    end

    // State and output registers; reset drops the bus immediately, even mid-strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= PWR_WAIT;
            idx_q    <= 3'd0;
            db_q     <= 8'h00;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            cuenta_q <= 1'b0;
            listo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            db_q     <= db_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            cuenta_q <= cuenta_d;
            listo_q  <= listo_d;
        end
    end

    assign Cuenta = cuenta_q;
    assign Listo  = listo_q;
    assign LCD_RS = rs_q;
    assign LCD_RW = 1'b0;
    assign LCD_E  = e_q;
    assign LCD_DB = db_q;

endmodule
